// File: rtl/sram_axil_resp.sv
// AXI4-Lite-style single-outstanding memory responder with programmable latency over a 64-bit word array.
// Optional decode-error checking is enabled with `define SRAM_AXIL_DECERR_EN.
module sram_axil_resp #(
    parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LAT        = 2
) (
    input  logic        sram_clk_i,
    input  logic        sram_rst_n_i,
    input  logic        sram_arvalid_i,
    output logic        sram_arready_o,
    input  logic [63:0] sram_araddr_i,
    output logic        sram_rvalid_o,
    input  logic        sram_rready_i,
    output logic [63:0] sram_rdata_o,
    output logic [1:0]  sram_rresp_o,
    input  logic        sram_awvalid_i,
    output logic        sram_awready_o,
    input  logic [63:0] sram_awaddr_i,
    input  logic        sram_wvalid_i,
    output logic        sram_wready_o,
    input  logic [63:0] sram_wdata_i,
    input  logic [7:0]  sram_wstrb_i,
    output logic        sram_bvalid_o,
    input  logic        sram_bready_i,
    output logic [1:0]  sram_bresp_o
);
    localparam int         DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT    = 4'(LAT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    generate
        if (LAT < 1 || LAT > 15) begin : g_lat_chk
            $error("sram_axil_resp: LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    err_q;
    logic [63:0]             wdata_q;
    logic [7:0]              wstrb_q;
    logic [63:0]             mem [DEPTH];

    logic                    arready, awready;
    logic                    ar_hs, aw_hs;
    logic [63:0]             req_addr, req_off;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    req_err;
    logic                    unused_off;

    assign ar_hs    = sram_arvalid_i & arready;
    assign aw_hs    = awready;
    assign req_addr = ar_hs ? sram_araddr_i : sram_awaddr_i;
    assign req_off  = req_addr - BASE;
    assign req_idx  = req_off[DEPTH_LOG2+2:3];
    assign unused_off = ^{req_off[63:DEPTH_LOG2+3], req_off[2:0]};

`ifdef SRAM_AXIL_DECERR_EN
    // Below BASE wraps req_off high, so the shift test covers both ends of the window.
    assign req_err = (req_addr < BASE) || ((req_off >> (DEPTH_LOG2 + 3)) != 64'd0);
`else
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        case (state)
            IDLE: begin
                arready = sram_rst_n_i;
                awready = sram_rst_n_i & sram_awvalid_i & sram_wvalid_i & ~sram_arvalid_i;
                if (sram_arvalid_i & arready) state_nxt = RD_WAIT;
                else if (awready)             state_nxt = WR_WAIT;
            end
            RD_WAIT: if (cnt == 4'd0) state_nxt = RD_RESP;
            WR_WAIT: if (cnt == 4'd0) state_nxt = WR_RESP;
            RD_RESP: if (sram_rready_i) state_nxt = IDLE;
            WR_RESP: if (sram_bready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sram_arready_o = arready;
    assign sram_awready_o = awready;
    assign sram_wready_o  = awready;
    assign sram_rvalid_o  = (state == RD_RESP);
    assign sram_bvalid_o  = (state == WR_RESP);

    always_ff @(posedge sram_clk_i or negedge sram_rst_n_i) begin
        if (!sram_rst_n_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            sram_rdata_o <= '0;
            sram_rresp_o <= RESP_OKAY;
            sram_bresp_o <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (ar_hs || aw_hs) begin
                cnt   <= CNT_INIT;
                idx_q <= req_idx;
                err_q <= req_err;
                if (aw_hs) begin
                    wdata_q <= sram_wdata_i;
                    wstrb_q <= sram_wstrb_i;
                end
            end else if ((state == RD_WAIT || state == WR_WAIT) && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Response fields load only on entry to the RESP state, so they hold under backpressure.
            if (state == RD_WAIT && cnt == 4'd0) begin
                sram_rdata_o <= err_q ? 64'd0 : mem[idx_q];
                sram_rresp_o <= err_q ? RESP_DECERR : RESP_OKAY;
            end
            if (state == WR_WAIT && cnt == 4'd0)
                sram_bresp_o <= err_q ? RESP_DECERR : RESP_OKAY;
        end
    end

    // Commit happens on the WR_WAIT -> WR_RESP edge; a reset before then leaves the array untouched.
    always_ff @(posedge sram_clk_i) begin
        if (state == WR_WAIT && cnt == 4'd0 && !err_q) begin
            for (int b = 0; b < 8; b++)
                if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end
endmodule
